control_compuertas: RTL and testbench

Downstream stage of the coffee-bean grade classifier. It captures each bean's 2-bit grade (00 BAJA, 01 MEDIA, 10 ALTA) at the detection point. It queues the bean for the conveyor transit time, then pulses the matching diverter gate when the bean reaches the gates. It also keeps per-grade saturating bean counters and sticky error flags for the supervisory logic.

---
 rtl/control_compuertas_if.sv | 45 ++++
 rtl/control_compuertas.sv | 195 +++++++++++++++++++
 tb/tb_control_compuertas.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/control_compuertas_if.sv
// -----------------------------------------------------------------------------
// control_compuertas_if
// Groups the bean-capture inputs and the gate/status outputs of the
// control_compuertas stage.
//   master : drives bean_detect, grade, clr_counts; observes gates/status
//   slave  : the gate controller itself
// Ports carried:
//   bean_detect, grade[1:0], clr_counts               (master -> slave)
//   gate_baja, gate_media, gate_alta, busy,
//   queue_level, count_baja/media/alta,
//   overflow_err, collision_err, invalid_grade        (slave -> master)
// -----------------------------------------------------------------------------
interface control_compuertas_if #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
);
    logic                     bean_detect;
    logic [1:0]               grade;
    logic                     clr_counts;
    logic                     gate_baja;
    logic                     gate_media;
    logic                     gate_alta;
    logic                     busy;
    logic [$clog2(DEPTH):0]   queue_level;
    logic [CNT_W-1:0]         count_baja;
    logic [CNT_W-1:0]         count_media;
    logic [CNT_W-1:0]         count_alta;
    logic                     overflow_err;
    logic                     collision_err;
    logic                     invalid_grade;

    modport master (
        output bean_detect, grade, clr_counts,
        input  gate_baja, gate_media, gate_alta, busy, queue_level,
               count_baja, count_media, count_alta,
               overflow_err, collision_err, invalid_grade
    );

    modport slave (
        input  bean_detect, grade, clr_counts,
        output gate_baja, gate_media, gate_alta, busy, queue_level,
               count_baja, count_media, count_alta,
               overflow_err, collision_err, invalid_grade
    );
endinterface

// File: rtl/control_compuertas.sv
// -----------------------------------------------------------------------------
// control_compuertas
// Downstream stage of the coffee-bean grade classifier. Each rising edge of
// bean_detect captures the bean's grade together with the timestamp at which
// it will reach the diverter gates. When the oldest bean becomes due, the
// matching gate is pulsed for GATE_HOLD cycles and a per-grade saturating
// counter is bumped. Sticky flags report queue overflow, gate collisions and
// invalid (11) grades.
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : control_compuertas_if.slave (capture inputs, gates, status)
// -----------------------------------------------------------------------------
module control_compuertas #(
    parameter int DEPTH         = 8,
    parameter int TRAVEL_CYCLES = 50,
    parameter int GATE_HOLD     = 10,
    parameter int CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    control_compuertas_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    // Timestamp wide enough that TRAVEL_CYCLES < 2^TW, so equality against a
    // wrapped due time is unambiguous.
    localparam int TW = $clog2(TRAVEL_CYCLES) + 1;
    localparam int HW = $clog2(GATE_HOLD) + 1;

    typedef enum logic {IDLE, OPEN} state_t;

    typedef struct packed {
        logic [1:0]    grade;
        logic [TW-1:0] due;
    } entry_t;

    entry_t           fifo_q [DEPTH];
    entry_t           fifo_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [TW-1:0]    ts_q, ts_d;
    logic             bean_prev_q, bean_prev_d;
    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [2:0]       gates_q, gates_d;
    logic [CNT_W-1:0] cnt_baja_q, cnt_baja_d;
    logic [CNT_W-1:0] cnt_media_q, cnt_media_d;
    logic [CNT_W-1:0] cnt_alta_q, cnt_alta_d;
    logic             ovf_q, ovf_d;
    logic             col_q, col_d;
    logic             inv_q, inv_d;

    logic   detect, full, push, pop;
    entry_t head;

    // Capture, queue, gate sequencing and bookkeeping for one cycle.
    always_comb begin
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        ts_d        = ts_q + 1'b1;
        bean_prev_d = bus.bean_detect;
        state_d     = state_q;
        sel_d       = sel_q;
        hold_d      = hold_q;
        cnt_baja_d  = cnt_baja_q;
        cnt_media_d = cnt_media_q;
        cnt_alta_d  = cnt_alta_q;
        ovf_d       = ovf_q;
        col_d       = col_q;
        inv_d       = inv_q;

        detect = bus.bean_detect & ~bean_prev_q;
        head   = fifo_q[rd_ptr_q];
        pop    = (level_q != '0) && (head.due == ts_q);
        full   = (level_q == LW'(DEPTH));
        // A full queue still accepts a bean when the head leaves this cycle.
        push   = detect && (!full || pop);

        if (push) begin
            fifo_d[wr_ptr_q].grade = (bus.grade == 2'b11) ? 2'b00 : bus.grade;
            fifo_d[wr_ptr_q].due   = ts_q + TW'(TRAVEL_CYCLES);
            wr_ptr_d               = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (detect && full && !pop) ovf_d = 1'b1;
        if (detect && (bus.grade == 2'b11)) inv_d = 1'b1;

        // Gate FSM: a due bean always takes the gate, preempting an open one.
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = OPEN;
                    sel_d   = head.grade;
                    hold_d  = HW'(GATE_HOLD - 1);
                end
            end
            OPEN: begin
                if (pop) begin
                    sel_d  = head.grade;
                    hold_d = HW'(GATE_HOLD - 1);
                    col_d  = 1'b1;
                end else if (hold_q == '0) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        gates_d = 3'b000;
        if (state_d == OPEN) begin
            gates_d[0] = (sel_d == 2'b00);
            gates_d[1] = (sel_d == 2'b01);
            gates_d[2] = (sel_d == 2'b10);
        end

        if (pop && head.grade == 2'b00 && cnt_baja_q  != '1) cnt_baja_d  = cnt_baja_q  + 1'b1;
        if (pop && head.grade == 2'b01 && cnt_media_q != '1) cnt_media_d = cnt_media_q + 1'b1;
        if (pop && head.grade == 2'b10 && cnt_alta_q  != '1) cnt_alta_d  = cnt_alta_q  + 1'b1;

        // Clear beats any same-cycle increment or flag set.
        if (bus.clr_counts) begin
            cnt_baja_d  = '0;
            cnt_media_d = '0;
            cnt_alta_d  = '0;
            ovf_d       = 1'b0;
            col_d       = 1'b0;
            inv_d       = 1'b0;
        end
    end

    // State registers; reset discards everything in transit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ts_q        <= '0;
            bean_prev_q <= 1'b0;
            state_q     <= IDLE;
            sel_q       <= 2'b00;
            hold_q      <= '0;
            gates_q     <= 3'b000;
            cnt_baja_q  <= '0;
            cnt_media_q <= '0;
            cnt_alta_q  <= '0;
            ovf_q       <= 1'b0;
            col_q       <= 1'b0;
            inv_q       <= 1'b0;
        end else begin
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ts_q        <= ts_d;
            bean_prev_q <= bean_prev_d;
            state_q     <= state_d;
            sel_q       <= sel_d;
            hold_q      <= hold_d;
            gates_q     <= gates_d;
            cnt_baja_q  <= cnt_baja_d;
            cnt_media_q <= cnt_media_d;
            cnt_alta_q  <= cnt_alta_d;
            ovf_q       <= ovf_d;
            col_q       <= col_d;
            inv_q       <= inv_d;
        end
    end

    assign bus.gate_baja     = gates_q[0];
    assign bus.gate_media    = gates_q[1];
    assign bus.gate_alta     = gates_q[2];
    assign bus.busy          = (level_q != '0) || (state_q == OPEN);
    assign bus.queue_level   = level_q;
    assign bus.count_baja    = cnt_baja_q;
    assign bus.count_media   = cnt_media_q;
    assign bus.count_alta    = cnt_alta_q;
    assign bus.overflow_err  = ovf_q;
    assign bus.collision_err = col_q;
    assign bus.invalid_grade = inv_q;
endmodule

// File: tb/tb_control_compuertas.sv
// -----------------------------------------------------------------------------
// tb_control_compuertas
// Directed bench for control_compuertas. dut_a uses default parameters,
// dut_b uses CNT_W=4 to exercise counter saturation. Inputs change and
// outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_control_compuertas;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   fire_seen;

    control_compuertas_if #(.DEPTH(8), .CNT_W(16)) bus_a ();
    control_compuertas_if #(.DEPTH(8), .CNT_W(4))  bus_b ();

    control_compuertas #(.DEPTH(8), .TRAVEL_CYCLES(50), .GATE_HOLD(10), .CNT_W(16)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    control_compuertas #(.DEPTH(8), .TRAVEL_CYCLES(50), .GATE_HOLD(10), .CNT_W(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One-cycle bean pulse on dut_a; returns just after detection edge T.
    task automatic bean_a(input logic [1:0] g);
        bus_a.bean_detect = 1'b1;
        bus_a.grade       = g;
        @(negedge clk);
        bus_a.bean_detect = 1'b0;
        bus_a.grade       = 2'b00;
    endtask

    task automatic clear_a();
        bus_a.clr_counts = 1'b1;
        @(negedge clk);
        bus_a.clr_counts = 1'b0;
    endtask

    function automatic logic [2:0] gates_a();
        return {bus_a.gate_alta, bus_a.gate_media, bus_a.gate_baja};
    endfunction

    initial begin
        logic [1:0] seq [9];
        n_checks  = 0;
        n_fail    = 0;
        fire_seen = 0;
        seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd0; seq[4] = 2'd1;
        seq[5] = 2'd2; seq[6] = 2'd0; seq[7] = 2'd1; seq[8] = 2'd2;

        rst_n = 1'b0;
        bus_a.bean_detect = 1'b0; bus_a.grade = 2'b00; bus_a.clr_counts = 1'b0;
        bus_b.bean_detect = 1'b0; bus_b.grade = 2'b00; bus_b.clr_counts = 1'b0;
        wait_n(3);
        check_output("reset_gates", 32'(gates_a()), 32'd0);
        check_output("reset_busy", 32'(bus_a.busy), 32'd0);
        check_output("reset_level", 32'(bus_a.queue_level), 32'd0);
        check_output("reset_flags", 32'({bus_a.overflow_err, bus_a.collision_err, bus_a.invalid_grade}), 32'd0);
        check_output("reset_count", 32'(bus_a.count_baja), 32'd0);
        rst_n = 1'b1;
        wait_n(2);

        // Single grade-10 bean.
        bean_a(2'b10);
        check_output("single_level", 32'(bus_a.queue_level), 32'd1);
        check_output("single_busy", 32'(bus_a.busy), 32'd1);
        wait_n(49);
        check_output("single_t49", 32'(gates_a()), 32'd0);
        wait_n(1);
        check_output("single_t50", 32'(gates_a()), 32'b100);
        check_output("single_count", 32'(bus_a.count_alta), 32'd1);
        check_output("single_level0", 32'(bus_a.queue_level), 32'd0);
        wait_n(9);
        check_output("single_t59", 32'(gates_a()), 32'b100);
        wait_n(1);
        check_output("single_t60", 32'(gates_a()), 32'd0);
        check_output("single_busy0", 32'(bus_a.busy), 32'd0);

        // Level held high for 20 cycles counts as one bean.
        bus_a.bean_detect = 1'b1;
        bus_a.grade       = 2'b01;
        wait_n(20);
        bus_a.bean_detect = 1'b0;
        check_output("held_level", 32'(bus_a.queue_level), 32'd1);
        wait_n(30);
        check_output("held_t49", 32'(gates_a()), 32'd0);
        wait_n(1);
        check_output("held_t50", 32'(gates_a()), 32'b010);
        check_output("held_count", 32'(bus_a.count_media), 32'd1);
        wait_n(10);
        check_output("held_t60", 32'(gates_a()), 32'd0);
        check_output("held_level0", 32'(bus_a.queue_level), 32'd0);
        wait_n(2);

        // Nine beans every 2 cycles into a depth-8 queue.
        for (int i = 0; i < 9; i++) begin
            bean_a(seq[i]);
            if (i < 8) wait_n(1);
        end
        check_output("ovf_level", 32'(bus_a.queue_level), 32'd8);
        check_output("ovf_flag", 32'(bus_a.overflow_err), 32'd1);
        wait_n(34);
        for (int i = 0; i < 8; i++) begin
            check_output($sformatf("order_%0d", i), 32'(gates_a()), 32'(3'b001 << seq[i]));
            wait_n(2);
        end
        check_output("ovf_ninth", 32'(gates_a()), 32'b010);
        check_output("ovf_collision", 32'(bus_a.collision_err), 32'd1);
        wait_n(8);
        check_output("ovf_end", 32'(gates_a()), 32'd0);
        check_output("ovf_busy", 32'(bus_a.busy), 32'd0);
        check_output("ovf_cnt_baja", 32'(bus_a.count_baja), 32'd3);
        check_output("ovf_cnt_media", 32'(bus_a.count_media), 32'd4);
        check_output("ovf_cnt_alta", 32'(bus_a.count_alta), 32'd3);

        clear_a();
        check_output("clr_counts", 32'({bus_a.count_baja, bus_a.count_media}), 32'd0);
        check_output("clr_alta", 32'(bus_a.count_alta), 32'd0);
        check_output("clr_flags", 32'({bus_a.overflow_err, bus_a.collision_err, bus_a.invalid_grade}), 32'd0);

        // Collision: grade 00 then grade 10 four cycles later.
        bean_a(2'b00);
        wait_n(3);
        bean_a(2'b10);
        wait_n(46);
        check_output("col_t50", 32'(gates_a()), 32'b001);
        check_output("col_none", 32'(bus_a.collision_err), 32'd0);
        wait_n(3);
        check_output("col_t53", 32'(gates_a()), 32'b001);
        wait_n(1);
        check_output("col_t54", 32'(gates_a()), 32'b100);
        check_output("col_flag", 32'(bus_a.collision_err), 32'd1);
        check_output("col_cnt", 32'({bus_a.count_baja[7:0], bus_a.count_alta[7:0]}), 32'h0101);
        wait_n(9);
        check_output("col_t63", 32'(gates_a()), 32'b100);
        wait_n(1);
        check_output("col_t64", 32'(gates_a()), 32'd0);
        clear_a();

        // Invalid grade 11 routes to the baja gate.
        bean_a(2'b11);
        check_output("inv_flag", 32'(bus_a.invalid_grade), 32'd1);
        wait_n(50);
        check_output("inv_gate", 32'(gates_a()), 32'b001);
        check_output("inv_count", 32'(bus_a.count_baja), 32'd1);
        wait_n(10);
        check_output("inv_end", 32'(gates_a()), 32'd0);

        // Saturation on the 4-bit counter instance.
        for (int i = 0; i < 17; i++) begin
            bus_b.bean_detect = 1'b1;
            bus_b.grade       = 2'b01;
            wait_n(1);
            bus_b.bean_detect = 1'b0;
            wait_n(11);
        end
        wait_n(62);
        check_output("sat_count", 32'(bus_b.count_media), 32'd15);
        check_output("sat_nocol", 32'(bus_b.collision_err), 32'd0);
        check_output("sat_idle", 32'(bus_b.busy), 32'd0);
        bus_b.clr_counts = 1'b1;
        wait_n(1);
        bus_b.clr_counts = 1'b0;
        check_output("sat_clr", 32'(bus_b.count_media), 32'd0);

        // Reset with three beans in transit.
        bean_a(2'b00);
        wait_n(1);
        bean_a(2'b01);
        wait_n(1);
        bean_a(2'b10);
        check_output("rst_level3", 32'(bus_a.queue_level), 32'd3);
        rst_n = 1'b0;
        wait_n(2);
        check_output("rst_level0", 32'(bus_a.queue_level), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 70; i++) begin
            wait_n(1);
            if (gates_a() != 3'b000) fire_seen++;
        end
        check_output("rst_nofire", 32'(fire_seen), 32'd0);
        check_output("rst_counts", 32'({bus_a.count_baja[7:0], bus_a.count_media[7:0], bus_a.count_alta[7:0]}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
